// File: rtl/pll_ce_sequencer.sv
// ---------------------------------------------------------------------------
// pll_ce_sequencer
//
// Models a multi-output PLL inside a single clock domain: a lock sequencer
// followed by CHANNELS divided clock-enable strobes, each with a
// programmable divide ratio and phase offset. Each channel owns a capture
// register that samples the synchronised input pipeline when its strobe fires.
//
// Ports
//   clk        in   1               sole clock, rising edge
//   cpu_reset  in   1               asynchronous active-high reset of all state
//   pll_rst    in   1               synchronous restart of the lock sequence
//   data_in    in   WIDTH           input data
//   data_sync  out  WIDTH           data_in after SYNC_STAGES registers
//   locked     out  1               lock indicator (registered)
//   ce         out  CHANNELS        per-channel registered one-cycle strobes
//   data_out   out  CHANNELS*WIDTH  per-channel captured data, field i at
//                                   [i*WIDTH +: WIDTH]
//
// Handshake: there is no valid/ready pair. ce[i] acts as a valid qualifier
// for channel i; downstream logic must accept on every cycle ce[i] is high.
// ---------------------------------------------------------------------------
module pll_ce_sequencer #(
  parameter int                          CHANNELS    = 3,
  parameter int                          WIDTH       = 1,
  parameter int                          DIV_W       = 8,
  parameter logic [CHANNELS*DIV_W-1:0]   DIVIDE      = {8'd6, 8'd3, 8'd12},
  parameter logic [CHANNELS*DIV_W-1:0]   PHASE       = {8'd1, 8'd0, 8'd3},
  parameter int                          LOCK_CYCLES = 16,
  parameter int                          SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      cpu_reset,
  input  logic                      pll_rst,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_sync,
  output logic                      locked,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS*WIDTH-1:0] data_out
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("pll_ce_sequencer: CHANNELS must be in 1..16");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("pll_ce_sequencer: LOCK_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 1) begin : g_bad_sync
    $error("pll_ce_sequencer: SYNC_STAGES must be >= 1");
  end

  // -------------------------------------------------------------------------
  // Input pipeline: free-running shift chain, independent of lock state
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign data_sync = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Lock sequencer
  // -------------------------------------------------------------------------
  localparam int             LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_TERM = LCW'(LOCK_CYCLES - 1);

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q    <= ST_WAIT;
      lock_cnt_q <= '0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked     <= (state_d == ST_LOCKED);
    end
  end

  // pll_rst takes priority over the terminal count, so a restart that lands
  // on the lock edge keeps locked low.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (pll_rst) begin
      state_d    = ST_WAIT;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          // Counter saturates at the terminal value instead of wrapping.
          if (lock_cnt_q == LOCK_TERM) state_d = ST_LOCKED;
          else                         lock_cnt_d = lock_cnt_q + LCW'(1);
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_WAIT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel divider, strobe and capture register
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV_I = DIVIDE[i*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] PH_I  = PHASE[i*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] TOP_I = DIV_I - DIV_W'(1);

    if (DIV_I == '0) begin : g_bad_div
      $error("pll_ce_sequencer: DIVIDE field must be >= 1");
    end
    if (PH_I >= DIV_I) begin : g_bad_phase
      $error("pll_ce_sequencer: PHASE field must be < DIVIDE field");
    end

    logic [DIV_W-1:0] cnt_q;
    logic             ce_q;
    logic [WIDTH-1:0] cap_q;

    // Counters only run while the registered lock flag is high, so every
    // channel leaves 0 on the same edge and the strobes stay phase-aligned.
    always_ff @(posedge clk or posedge cpu_reset) begin
      if (cpu_reset) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else if (pll_rst || !locked) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else begin
        cnt_q <= (cnt_q == TOP_I) ? '0 : cnt_q + DIV_W'(1);
        ce_q  <= (cnt_q == PH_I);
      end
    end

    // Capture is deliberately untouched by pll_rst or loss of lock.
    always_ff @(posedge clk or posedge cpu_reset) begin
      if (cpu_reset)  cap_q <= '0;
      else if (ce_q)  cap_q <= data_sync;
    end

    assign ce[i]                      = ce_q;
    assign data_out[i*WIDTH +: WIDTH] = cap_q;
  end

endmodule
